// File: rtl/fp_mul_iter_ctrl.sv
// Sequential binary32 multiplier: one radix-4 Booth step per cycle over 13 cycles,
// with special-operand bypass, exponent tracking and truncating normalization.
module fp_mul_iter_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [3:0]         r_cnt;
    logic [26:0]        r_acc;
    logic [27:0]        r_q;
    logic [23:0]        r_mb;
    logic               r_sign;
    logic signed [9:0]  r_exp;
    logic [31:0]        r_result;

    logic        w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan;
    logic        w_sign_in, w_special;
    logic [31:0] w_special_res;
    logic [26:0] w_mb1, w_mb2, w_addend, w_sum;
    logic        w_p47;
    logic [22:0] w_frac;
    logic signed [9:0] w_exp_n;
    logic [31:0] w_norm_res;

    // Denormals have E=0 and fall into the zero class (flush to zero).
    assign w_a_zero  = (a[30:23] == 8'd0);
    assign w_b_zero  = (b[30:23] == 8'd0);
    assign w_a_inf   = (&a[30:23]) && (a[22:0] == 23'd0);
    assign w_b_inf   = (&b[30:23]) && (b[22:0] == 23'd0);
    assign w_a_nan   = (&a[30:23]) && (a[22:0] != 23'd0);
    assign w_b_nan   = (&b[30:23]) && (b[22:0] != 23'd0);
    assign w_sign_in = a[31] ^ b[31];
    assign w_special = w_a_zero | w_b_zero | w_a_inf | w_b_inf | w_a_nan | w_b_nan;

    always_comb begin
        w_special_res = {w_sign_in, 31'd0};
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_inf) || (w_a_inf && w_b_zero))
            w_special_res = 32'h7FC00000;
        else if (w_a_inf || w_b_inf)
            w_special_res = {w_sign_in, 8'hFF, 23'd0};
    end

    assign w_mb1 = {3'b000, r_mb};
    assign w_mb2 = {2'b00, r_mb, 1'b0};

    always_comb begin
        w_addend = '0;
        case (r_q[2:0])
            3'b001, 3'b010: w_addend = w_mb1;
            3'b011:         w_addend = w_mb2;
            3'b100:         w_addend = -w_mb2;
            3'b101, 3'b110: w_addend = -w_mb1;
            default:        w_addend = '0;
        endcase
    end

    assign w_sum = r_acc + w_addend;

    // P = {acc, q}[49:2]; pick the P[47], P[46:24] and P[45:23] slices directly.
    assign w_p47   = r_acc[21];
    assign w_frac  = w_p47 ? {r_acc[20:0], r_q[27:26]} : {r_acc[19:0], r_q[27:25]};
    assign w_exp_n = w_p47 ? (r_exp + 10'sd1) : r_exp;

    always_comb begin
        w_norm_res = {r_sign, w_exp_n[7:0], w_frac};
        if (w_exp_n >= 10'sd255)
            w_norm_res = {r_sign, 8'hFF, 23'd0};
        else if (w_exp_n <= 10'sd0)
            w_norm_res = {r_sign, 31'd0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_next = w_special ? S_DONE : S_MUL;
            S_MUL:  if (r_cnt == 4'd12) w_next = S_NORM;
            S_NORM: w_next = S_DONE;
            S_DONE: if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_mb     <= '0;
            r_sign   <= 1'b0;
            r_exp    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_cnt  <= '0;
                    r_acc  <= '0;
                    r_q    <= {3'b000, 1'b1, a[22:0], 1'b0};
                    r_mb   <= {1'b1, b[22:0]};
                    r_sign <= w_sign_in;
                    r_exp  <= $signed({2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127);
                    if (w_special)
                        r_result <= w_special_res;
                end
                S_MUL: begin
                    r_acc <= {{2{w_sum[26]}}, w_sum[26:2]};
                    r_q   <= {w_sum[1:0], r_q[27:2]};
                    r_cnt <= r_cnt + 4'd1;
                end
                S_NORM: r_result <= w_norm_res;
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;

endmodule

// File: tb/tb_fp_mul_iter_ctrl.sv
// Directed bench for fp_mul_iter_ctrl: table of operand/result/latency vectors
// plus hand-written backpressure and mid-operation reset sequences.
module tb_fp_mul_iter_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        int          hold;
    } vec_t;

    vec_t vecs[11];

    fp_mul_iter_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Entered and left at posedge+1. Operands are scrambled and in_valid kept
    // high while busy to show they are ignored.
    task automatic run_op(input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] vexp, input int lat, input int hold);
        int cyc;
        logic [31:0] held;
        a = va; b = vb; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        chk("in_ready_before", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        a = $urandom; b = $urandom;
        cyc = 1;
        chk("in_ready_after_capture", {31'd0, in_ready}, 32'd0);
        while (!out_valid && cyc < 40) begin
            chk("busy", {31'd0, busy}, 32'd1);
            @(posedge clk); #1;
            a = $urandom; b = $urandom;
            cyc++;
        end
        chk("latency", cyc, lat);
        chk("result", result, vexp);
        chk("busy_done", {31'd0, busy}, 32'd1);
        held = result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            a = $urandom; b = $urandom;
            chk("bp_result", result, held);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
        chk("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
        chk("result_held", result, held);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 15, 0};
        vecs[1]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 15, 10};
        vecs[2]  = '{32'h40400000, 32'hC0000000, 32'hC0C00000, 15, 0};
        vecs[3]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 15, 0};
        vecs[4]  = '{32'h00800000, 32'h00800000, 32'h00000000, 15, 0};
        vecs[5]  = '{32'h3F800000, 32'hBF800000, 32'hBF800000, 15, 0};
        vecs[6]  = '{32'h00000000, 32'h7F800000, 32'h7FC00000, 1, 0};
        vecs[7]  = '{32'h80000000, 32'h3F800000, 32'h80000000, 1, 10};
        vecs[8]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 1, 0};
        vecs[9]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 1, 0};
        vecs[10] = '{32'h00000001, 32'h3F800000, 32'h00000000, 1, 0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_result", result, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].hold);

        // Asynchronous reset in the middle of Booth step 6 (cycle 7).
        a = 32'h3F800000; b = 32'h3F800000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", {31'd0, busy}, 32'd0);
        run_op(32'h3F800000, 32'h40000000, 32'h40000000, 15, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
